// File: rtl/uart_pkg.sv
// UART receive types shared by uart_rx and its optional FIFO.
package uart_pkg;
  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BRK    = 3'd5
  } rx_state_e;

  typedef struct packed {
    logic                      perr;
    logic                      ferr;
    logic [UART_DATA_BITS-1:0] data;
  } rx_entry_t;
endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO of received frames; pointers carry an extra wrap bit
// so full and empty are distinguishable without a count register.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_i,
  input  logic      i_push,
  input  rx_entry_t i_din,
  input  logic      i_pop,
  output rx_entry_t o_dout,
  output logic      o_full,
  output logic      o_empty
);
  localparam int AW = $clog2(DEPTH);

  rx_entry_t     r_mem [DEPTH];
  logic [AW:0]   r_wptr, r_rptr;
  logic          w_wr, w_rd;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  // A push into a full FIFO is still legal when the head leaves the same cycle.
  assign w_wr    = i_push && (!o_full || i_pop);
  assign w_rd    = i_pop && !o_empty;
  assign o_dout  = r_mem[r_rptr[AW-1:0]];

  // Pointer update
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage write; contents are don't-care while empty
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_din;
  end
endmodule

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer, mid-bit sampling FSM, 8 data bits
// LSB first, optional even parity (XOR of data), one stop bit.
// Build option UART_RX_FIFO_EN: buffer frames in a FIFO_DEPTH-entry FIFO
// with ready/valid pop; otherwise rx_valid_o is a one-cycle pulse per frame.
module uart_rx
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_i,
  input  logic [31:0] clk_div_i,
  input  logic        parity_en_i,
  input  logic        rx_i,
  output logic [7:0]  rx_data_o,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  output logic        parity_err_o,
  output logic        frame_err_o,
  output logic        overrun_o
);
  rx_state_e   r_state, w_next;
  logic [1:0]  r_sync;
  logic [31:0] r_cnt, r_div;
  logic        r_par_en, r_par, r_perr;
  logic [2:0]  r_idx;
  logic [7:0]  r_sh;
  logic        w_rx_s, w_tick;
  logic        w_start, w_reload, w_shift, w_par_chk, w_done;
  rx_entry_t   w_entry;

  assign w_rx_s  = r_sync[1];
  assign w_tick  = (r_cnt == 32'd0);
  assign w_entry = '{perr: r_perr, ferr: ~w_rx_s, data: r_sh};

  // Line synchronizer, resets to idle-high so reset never looks like a start bit
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) r_sync <= 2'b11;
    else       r_sync <= {r_sync[0], rx_i};
  end

  // State register
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:   if (!w_rx_s) w_next = START;
      START:  if (w_tick)  w_next = w_rx_s ? IDLE : DATA;
      DATA:   if (w_tick && r_idx == 3'd7) w_next = r_par_en ? PARITY : STOP;
      PARITY: if (w_tick)  w_next = STOP;
      STOP:   if (w_tick)  w_next = w_rx_s ? IDLE : BRK;
      BRK:    if (w_rx_s)  w_next = IDLE;
      default:             w_next = IDLE;
    endcase
  end

  // Per-state datapath strobes
  always_comb begin
    w_start   = 1'b0;
    w_reload  = 1'b0;
    w_shift   = 1'b0;
    w_par_chk = 1'b0;
    w_done    = 1'b0;
    case (r_state)
      IDLE:   w_start  = !w_rx_s;
      START:  w_reload = w_tick && !w_rx_s;
      DATA:   begin w_shift = w_tick; w_reload = w_tick; end
      PARITY: begin w_par_chk = w_tick; w_reload = w_tick; end
      STOP:   w_done   = w_tick;
      default: ;
    endcase
  end

  // Bit timer, shift register and parity; baud/parity settings frozen per frame
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      r_cnt    <= '0;
      r_div    <= '0;
      r_par_en <= 1'b0;
      r_par    <= 1'b0;
      r_perr   <= 1'b0;
      r_idx    <= '0;
      r_sh     <= '0;
    end else begin
      if (w_start) begin
        r_cnt    <= clk_div_i >> 1;
        r_div    <= clk_div_i;
        r_par_en <= parity_en_i;
        r_par    <= 1'b0;
        r_perr   <= 1'b0;
        r_idx    <= '0;
      end else if (w_reload) begin
        r_cnt <= r_div;
      end else if (!w_tick) begin
        r_cnt <= r_cnt - 32'd1;
      end
      if (w_shift) begin
        r_sh[r_idx] <= w_rx_s;
        r_par       <= r_par ^ w_rx_s;
        r_idx       <= r_idx + 3'd1;
      end
      if (w_par_chk) r_perr <= (w_rx_s != r_par);
    end
  end

`ifdef UART_RX_FIFO_EN
  rx_entry_t w_head;
  logic      w_full, w_empty, w_pop, r_ovr;

  assign w_pop = !w_empty && rx_ready_i;

  uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_i   (rst_i),
    .i_push  (w_done),
    .i_din   (w_entry),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Overrun pulse when a completed frame finds no room
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) r_ovr <= 1'b0;
    else       r_ovr <= w_done && w_full && !w_pop;
  end

  // Head entry is masked while empty so idle outputs read as zero
  assign rx_valid_o   = !w_empty;
  assign rx_data_o    = w_empty ? 8'h00 : w_head.data;
  assign parity_err_o = !w_empty && w_head.perr;
  assign frame_err_o  = !w_empty && w_head.ferr;
  assign overrun_o    = r_ovr;
`else
  rx_entry_t r_out;
  logic      r_valid;
  logic      w_unused;

  assign w_unused = ^{rx_ready_i, FIFO_DEPTH[0]};

  // Frame result register: one-cycle valid, data/flags held until next frame
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      r_valid <= 1'b0;
      r_out   <= '0;
    end else begin
      r_valid <= w_done;
      if (w_done) r_out <= w_entry;
    end
  end

  assign rx_valid_o   = r_valid;
  assign rx_data_o    = r_out.data;
  assign parity_err_o = r_out.perr;
  assign frame_err_o  = r_out.ferr;
  assign overrun_o    = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: bit-level serial driver, negedge monitor,
// hand-computed expected bytes and flags.
module tb_uart_rx;
  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] clk_div_i;
  logic        parity_en_i;
  logic        rx_i;
  logic [7:0]  rx_data_o;
  logic        rx_valid_o;
  logic        rx_ready_i;
  logic        parity_err_o;
  logic        frame_err_o;
  logic        overrun_o;

  int n_chk = 0;
  int n_fail = 0;
  int n_frm = 0;
  int n_ovr = 0;
  int base_frm = 0;
  bit mon_en = 1'b1;
  logic [7:0] cap_data;
  logic       cap_perr, cap_ferr;

  uart_rx #(.FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .rst_i        (rst_i),
    .clk_div_i    (clk_div_i),
    .parity_en_i  (parity_en_i),
    .rx_i         (rx_i),
    .rx_data_o    (rx_data_o),
    .rx_valid_o   (rx_valid_o),
    .rx_ready_i   (rx_ready_i),
    .parity_err_o (parity_err_o),
    .frame_err_o  (frame_err_o),
    .overrun_o    (overrun_o)
  );

  always #5 clk = ~clk;

  // Sample outputs on the falling edge, away from register updates
  always @(negedge clk) begin
    if (!rst_i) begin
      if (mon_en && rx_valid_o) begin
        n_frm++;
        cap_data = rx_data_o;
        cap_perr = parity_err_o;
        cap_ferr = frame_err_o;
      end
      if (overrun_o) n_ovr++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit has_par, input bit pbit,
                            input bit stop, input int bper);
    rx_i = 1'b0; wait_clk(bper);
    for (int i = 0; i < 8; i++) begin
      rx_i = d[i]; wait_clk(bper);
    end
    if (has_par) begin
      rx_i = pbit; wait_clk(bper);
    end
    rx_i = stop; wait_clk(bper);
    rx_i = 1'b1;
  endtask

  task automatic expect_frame(input string tag, input logic [7:0] d, input bit pe, input bit fe);
    chk({tag, "_count"}, n_frm - base_frm, 1);
    chk({tag, "_data"},  cap_data, d);
    chk({tag, "_perr"},  cap_perr, pe);
    chk({tag, "_ferr"},  cap_ferr, fe);
    base_frm = n_frm;
  endtask

  initial begin
    rst_i       = 1'b1;
    clk_div_i   = 32'd9;
    parity_en_i = 1'b0;
    rx_i        = 1'b1;
    rx_ready_i  = 1'b1;
    wait_clk(3);
    chk("rst_valid", rx_valid_o, 0);
    chk("rst_data",  rx_data_o, 0);
    chk("rst_perr",  parity_err_o, 0);
    chk("rst_ferr",  frame_err_o, 0);
    chk("rst_ovr",   overrun_o, 0);
    rst_i = 1'b0;
    wait_clk(5);

    // Plain 8N1 frame
    send_frame(8'hA5, 0, 0, 1, 10); wait_clk(20);
    expect_frame("a5", 8'hA5, 0, 0);

    // Parity enabled: good and bad parity bits
    parity_en_i = 1'b1;
    send_frame(8'h3C, 1, 0, 1, 10); wait_clk(20);
    expect_frame("3c_par_ok", 8'h3C, 0, 0);
    send_frame(8'h3C, 1, 1, 1, 10); wait_clk(20);
    expect_frame("3c_par_bad", 8'h3C, 1, 0);
    send_frame(8'h07, 1, 1, 1, 10); wait_clk(20);
    expect_frame("07_par_ok", 8'h07, 0, 0);
    parity_en_i = 1'b0;

    // Settings changed mid-frame must not affect the frame in flight
    fork
      send_frame(8'h6A, 0, 0, 1, 10);
      begin
        wait_clk(15);
        clk_div_i   = 32'd30;
        parity_en_i = 1'b1;
      end
    join
    wait_clk(20);
    expect_frame("latch", 8'h6A, 0, 0);
    clk_div_i   = 32'd9;
    parity_en_i = 1'b0;
    wait_clk(10);

    // Minimum legal divider
    clk_div_i = 32'd3;
    send_frame(8'hC3, 0, 0, 1, 4); wait_clk(10);
    expect_frame("div3", 8'hC3, 0, 0);
    clk_div_i = 32'd9;
    wait_clk(10);

    // Stop bit low then line held low: one frame, framing error, no re-trigger
    send_frame(8'h81, 0, 0, 0, 10);
    rx_i = 1'b0;
    wait_clk(30);
    chk("brk_low_count", n_frm - base_frm, 1);
    rx_i = 1'b1;
    wait_clk(40);
    expect_frame("brk", 8'h81, 0, 1);

    // Reset during data bit 4 of 0x55; line left high afterwards
    rx_i = 1'b0; wait_clk(10);
    for (int i = 0; i < 4; i++) begin
      rx_i = i[0] ? 1'b0 : 1'b1; wait_clk(10);
    end
    rx_i = 1'b1; wait_clk(5);
    rst_i = 1'b1; wait_clk(1);
    rst_i = 1'b0;
    chk("midrst_data",  rx_data_o, 0);
    chk("midrst_ferr",  frame_err_o, 0);
    chk("midrst_valid", rx_valid_o, 0);
    wait_clk(100);
    chk("midrst_nofrm", n_frm - base_frm, 0);
    send_frame(8'h55, 0, 0, 1, 10); wait_clk(20);
    expect_frame("after_rst", 8'h55, 0, 0);

    // Short glitch is rejected; receiver still accepts the next frame
    rx_i = 1'b0; wait_clk(3);
    rx_i = 1'b1; wait_clk(60);
    chk("glitch_nofrm", n_frm - base_frm, 0);
    send_frame(8'h0F, 0, 0, 1, 10); wait_clk(20);
    expect_frame("after_glitch", 8'h0F, 0, 0);

`ifdef UART_RX_FIFO_EN
    // Fill FIFO with ready low; fifth frame overruns; drain in order
    mon_en     = 1'b0;
    rx_ready_i = 1'b0;
    for (int k = 1; k <= 5; k++) send_frame(k[7:0], 0, 0, 1, 10);
    wait_clk(20);
    chk("fifo_ovr", n_ovr, 1);
    for (int k = 1; k <= 4; k++) begin
      chk("fifo_valid", rx_valid_o, 1);
      chk("fifo_data", rx_data_o, k);
      rx_ready_i = 1'b1; wait_clk(1);
      rx_ready_i = 1'b0;
    end
    chk("fifo_empty", rx_valid_o, 0);
`else
    chk("no_overrun", n_ovr, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
